// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures period and high time of a divided clock
// sampled on clk50, checks the period against EXP_PERIOD +/- TOL, and
// reports tick, measurement, lock, stall and fault status.
// Optional build macro DUTY_CHECK_EN: also checks high time against
// EXP_HIGH +/- TOL; when undefined the high counter is absent and
// high_out is tied to 0.
module clk_period_monitor #(
   parameter int CNT_W      = 16,
   parameter int EXP_PERIOD = 326,
   parameter int EXP_HIGH   = 163,
   parameter int TOL        = 2,
   parameter int LOCK_COUNT = 4,
   parameter int TIMEOUT    = 652
) (
   input  logic             clk50,
   input  logic             rst_n,
   input  logic             clk_in,
   output logic             tick,
   output logic             meas_valid,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             locked,
   output logic             stall,
   output logic [7:0]       fault_cnt
);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] EXP_P_C   = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [7:0]       LOCK_C    = 8'(LOCK_COUNT);

   // Parameters that cannot be represented in the counters are rejected at elaboration
   if (EXP_PERIOD > 2**CNT_W - 1 || EXP_HIGH > 2**CNT_W - 1 ||
       TIMEOUT > 2**CNT_W - 1 || LOCK_COUNT < 1 || LOCK_COUNT > 255) begin : g_bad_params
      $error("clk_period_monitor: parameter out of range");
   end

   logic             sync1_q, sync2_q, hist_q;
   logic             rise;
   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   logic [CNT_W-1:0] period_dev;
   logic             period_ok, high_ok, meas_good, timeout;
   state_e           state_q;
   logic [7:0]       good_cnt_q;
   logic             tick_q, meas_valid_q, locked_q, stall_q;
   logic [CNT_W-1:0] period_out_q;
   logic [7:0]       fault_cnt_q;

   // Two-flop synchronizer for the asynchronous clk_in, plus one history flop for edge detection
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= clk_in;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign rise = sync2_q & ~hist_q;

   // Period counter restarts at 1 on each rise so its value at the next rise equals the period
   always_comb begin
      period_cnt_d = period_cnt_q;
      if (rise) begin
         period_cnt_d = CNT_W'(1);
      end else if (period_cnt_q != CNT_MAX) begin
         period_cnt_d = period_cnt_q + CNT_W'(1);
      end
   end

   // Period counter register
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt_q <= '0;
      end else begin
         period_cnt_q <= period_cnt_d;
      end
   end

   assign period_dev = (period_cnt_q >= EXP_P_C) ? (period_cnt_q - EXP_P_C)
                                                 : (EXP_P_C - period_cnt_q);
   assign period_ok  = (period_dev <= TOL_C);

`ifdef DUTY_CHECK_EN
   localparam logic [CNT_W-1:0] EXP_H_C = CNT_W'(EXP_HIGH);

   logic             fall;
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d, high_dev, high_out_q;

   assign fall = ~sync2_q & hist_q;

   // High counter restarts on a rise, counts while the synchronized input is high, holds after the fall
   always_comb begin
      high_cnt_d = high_cnt_q;
      if (rise) begin
         high_cnt_d = CNT_W'(1);
      end else if (fall) begin
         high_cnt_d = high_cnt_q;
      end else if (sync2_q && high_cnt_q != CNT_MAX) begin
         high_cnt_d = high_cnt_q + CNT_W'(1);
      end
   end

   // High counter register
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         high_cnt_q <= '0;
      end else begin
         high_cnt_q <= high_cnt_d;
      end
   end

   assign high_dev = (high_cnt_q >= EXP_H_C) ? (high_cnt_q - EXP_H_C)
                                             : (EXP_H_C - high_cnt_q);
   assign high_ok  = (high_dev <= TOL_C);
   assign high_out = high_out_q;
`else
   assign high_ok  = 1'b1;
   assign high_out = '0;
`endif

   assign meas_good = period_ok & high_ok;
   assign timeout   = (state_q != SEARCH) && !rise && (period_cnt_q >= TIMEOUT_C);

   // Lock state machine with registered status; a rise always takes priority over a timeout
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SEARCH;
         good_cnt_q   <= '0;
         tick_q       <= 1'b0;
         meas_valid_q <= 1'b0;
         period_out_q <= '0;
         locked_q     <= 1'b0;
         stall_q      <= 1'b0;
         fault_cnt_q  <= '0;
`ifdef DUTY_CHECK_EN
         high_out_q   <= '0;
`endif
      end else begin
         tick_q       <= rise;
         meas_valid_q <= 1'b0;
         locked_q     <= (state_q == LOCKED);
         if (rise) begin
            stall_q <= 1'b0;
            if (state_q == SEARCH) begin
               state_q    <= ACQUIRE;
               good_cnt_q <= '0;
            end else begin
               meas_valid_q <= 1'b1;
               period_out_q <= period_cnt_q;
`ifdef DUTY_CHECK_EN
               high_out_q   <= high_cnt_q;
`endif
               if (meas_good) begin
                  if (state_q == ACQUIRE) begin
                     if (good_cnt_q + 8'd1 >= LOCK_C) begin
                        state_q    <= LOCKED;
                        good_cnt_q <= '0;
                     end else begin
                        good_cnt_q <= good_cnt_q + 8'd1;
                     end
                  end
               end else begin
                  state_q    <= ACQUIRE;
                  good_cnt_q <= '0;
                  if (fault_cnt_q != 8'hFF) begin
                     fault_cnt_q <= fault_cnt_q + 8'd1;
                  end
               end
            end
         end else if (timeout) begin
            state_q    <= SEARCH;
            good_cnt_q <= '0;
            stall_q    <= 1'b1;
            locked_q   <= 1'b0;
         end
      end
   end

   assign tick       = tick_q;
   assign meas_valid = meas_valid_q;
   assign period_out = period_out_q;
   assign locked     = locked_q;
   assign stall      = stall_q;
   assign fault_cnt  = fault_cnt_q;

endmodule

// File: doc/clk_period_monitor.md
Name: clk_period_monitor

Overview:
- Receive-side companion to the team's 50 MHz clock divider (default divided output: period 326 clk50 cycles, high 163, low 163).
- Samples a divided clock on clk50, measures its period and high time, and checks the period against an expected value with a tolerance.
- Reports lock, stall and fault status.
- Sits beside the divider; its status feeds board bring-up logic.

Parameters:
- CNT_W, 16, width of period/high counters and outputs
- EXP_PERIOD, 326, expected period in clk50 cycles
- EXP_HIGH, 163, expected high time in clk50 cycles (used only with DUTY_CHECK_EN)
- TOL, 2, allowed absolute deviation (cycles) for period and high time
- LOCK_COUNT, 4, consecutive good measurements required to lock
- TIMEOUT, 652, clk50 cycles without a rising edge before stall

Ports:
- clk50  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- clk_in  input  1  monitored divided clock, asynchronous to clk50
- tick  output  1  one-cycle pulse per detected clk_in rising edge
- meas_valid  output  1  one-cycle pulse when period_out/high_out update
- period_out  output  CNT_W  last measured period
- high_out  output  CNT_W  last measured high time
- locked  output  1  high while in LOCKED
- stall  output  1  no clk_in edge within TIMEOUT cycles
- fault_cnt  output  8  count of bad measurements, saturating

Behaviour:
- Interface: one clock, clk50. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, synchronizer flops 0, state SEARCH.
- clk_in passes through 2 synchronizer flops plus 1 history flop.
- Rise = sync high & history low; fall = sync low & history high.
- tick is registered. It asserts 3 clk50 edges after the first edge that samples clk_in high.
- Period counter: loads 1 on a rise, otherwise increments, saturating at 2^CNT_W-1.
- Measured period = cycles between consecutive rises.
- High counter: loads 1 on a rise, increments while sync is high, freezes on a fall.
- On every rise except the first after reset or stall:
  - period_out <= period counter; high_out <= frozen high count.
  - meas_valid pulses in the same cycle as tick.
- Good measurement: |period - EXP_PERIOD| <= TOL. Compare with unsigned subtraction, larger minus smaller; no wrap.
- Bad measurement: fault_cnt += 1, saturating at 255. fault_cnt is cleared only by reset.
- State machine:
  - SEARCH: first rise -> ACQUIRE, good-count 0; no measurement produced.
  - ACQUIRE: good measurement increments good-count; bad resets it to 0. On reaching LOCK_COUNT -> LOCKED; locked asserts the cycle after that meas_valid.
  - LOCKED: bad measurement -> ACQUIRE with good-count 0; locked drops the next cycle.
  - Any state except SEARCH: period counter reaching TIMEOUT without a rise -> SEARCH, stall <= 1, locked <= 0.
- Simultaneous events: if a rise occurs in the cycle the counter would reach TIMEOUT, the rise wins; no stall.
- stall clears on the next rise. That rise is treated as the first edge, so no measurement is produced.
- Reset mid-measurement: everything returns to reset values immediately; partial counts are discarded.

Optional Feature:
- Macro: DUTY_CHECK_EN.
- Defined: a measurement is good only if the period check passes and |high - EXP_HIGH| <= TOL.
- Undefined: high time is not checked. The high counter is removed and high_out is tied to 0.

Test Plan:
- Reset, then drive 326/163 clk_in:
  - 2nd rise: meas_valid with period_out=326, high_out=163 (0 if macro off).
  - locked rises one cycle after the 5th rise's meas_valid; fault_cnt=0.
- Drive period 328 -> locks after 5 rises. Drive period 329 -> never locks; fault_cnt counts 1,2,3… per rise from the 2nd.
- Locked, then one 340-cycle period -> locked drops, fault_cnt=1. Relocks after 4 further good periods.
- Locked, then hold clk_in high -> stall=1 and locked=0 exactly 652 cycles after the last rise counter load. Next rise clears stall with no meas_valid.
- Pulse rst_n low mid-period while locked -> all outputs 0 at once. First rise after release gives tick but no meas_valid.
- With DUTY_CHECK_EN, period 326 at high 150 -> every measurement bad, no lock. Macro off, same stimulus -> locks.
